// File: rtl/divider_8by4_seq_pkg.sv
// Shared types and constants for the sequential 8/4 restoring divider.
// Optional feature macro used by this block: DIVIDER_DIV0_FLAG_EN.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    // Counter must be able to hold DIVIDEND_W itself.
    localparam int CNT_W = $clog2(DEF_DIVIDEND_W + 1);

endpackage

// File: rtl/divider_8by4_seq_if.sv
// Operand/result handshake bundle for divider_8by4_seq.
// DIVIDER_DIV0_FLAG_EN adds the div0 result flag.
interface divider_8by4_seq_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
`ifdef DIVIDER_DIV0_FLAG_EN
    logic                  div0;
`endif

    // Producer/consumer side (drives operands, takes results).
    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef DIVIDER_DIV0_FLAG_EN
        input  div0,
`endif
        input  in_ready, out_valid, quotient, remainder
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef DIVIDER_DIV0_FLAG_EN
        output div0,
`endif
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/divider_8by4_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference if it did not go negative.
module divider_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] rem_i,     // current remainder, always < divisor
    input  logic                 bit_i,     // next dividend bit (MSB first)
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_o
);
    // Shifted partial remainder needs one extra bit before the subtract.
    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W-1:0] diff;
    logic                 ge;

    assign shifted = {rem_i, bit_i};
    assign ge      = (shifted >= {1'b0, divisor_i});
    // When ge holds the true difference is < divisor, so the low bits suffice.
    assign diff    = shifted[DIVISOR_W-1:0] - divisor_i;
    assign rem_o   = ge ? diff : shifted[DIVISOR_W-1:0];
    assign q_o     = ge;
endmodule

// File: rtl/divider_8by4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready on both sides. DIVIDER_DIV0_FLAG_EN adds a registered div0 flag.
module divider_8by4_seq
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic              clk,
    input  logic              rst,
    divider_8by4_seq_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_W + 1);

    state_t                state_q, state_d;
    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    divider_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath update.
    // A zero divisor still spends one RUN cycle (no iteration) so its result
    // appears one cycle after acceptance rather than in the same cycle.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d   = bus.divisor;
                    cnt_d   = CW'(DIVIDEND_W);
                    state_d = RUN;
                    if (bus.divisor == '0) begin
                        dvd_d = '1;
                        rem_d = bus.dividend[DIVISOR_W-1:0];
                    end else begin
                        dvd_d = bus.dividend;
                        rem_d = '0;
                    end
                end
            end
            RUN: begin
                if (dvs_q == '0) begin
                    state_d = DONE;
                end else begin
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                    rem_d = step_rem;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DIVIDER_DIV0_FLAG_EN
    logic div0_q, div0_d;

    // div0 rises with out_valid for a zero divisor and drops with it.
    always_comb begin
        div0_d = div0_q;
        if (state_q == RUN && dvs_q == '0)         div0_d = 1'b1;
        else if (state_q == DONE && bus.out_ready) div0_d = 1'b0;
    end

    // div0 flag register.
    always_ff @(posedge clk) begin
        if (rst) div0_q <= 1'b0;
        else     div0_q <= div0_d;
    end

    assign bus.div0 = div0_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = dvd_q;
    assign bus.remainder = rem_q;
endmodule

// File: tb/tb_divider_8by4_seq.sv
// Self-checking bench for divider_8by4_seq: directed cases, stall, mid-run
// reset, and a full operand sweep against a plain-arithmetic model.
module tb_divider_8by4_seq;
    localparam int DW = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    divider_8by4_seq_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus_if ();

    divider_8by4_seq #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic accept(input int a, input int b);
        int w = 0;
        while (!bus_if.in_ready && w < 30) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", 32'(bus_if.in_ready), 1);
        bus_if.in_valid = 1'b1;
        bus_if.dividend = DW'(a);
        bus_if.divisor  = SW'(b);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.dividend = DW'($urandom);
        bus_if.divisor  = SW'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 40) chk("out_valid_timeout", 32'(bus_if.out_valid), 1);
    endtask

    task automatic check_result(input int a, input int b, input string tag);
        int eq, er;
        int q, r;
        if (b == 0) begin
            eq = 255;
            er = a % 16;
        end else begin
            eq = a / b;
            er = a % b;
        end
        q = int'(bus_if.quotient);
        r = int'(bus_if.remainder);
        chk({tag, "_quot"}, 32'(q), 32'(eq));
        chk({tag, "_rem"}, 32'(r), 32'(er));
        if (b != 0)
            chk({tag, "_invariant"}, 32'((q * b + r == a) && (r < b)), 1);
`ifdef DIVIDER_DIV0_FLAG_EN
        chk({tag, "_div0"}, 32'(bus_if.div0), 32'(b == 0));
`endif
    endtask

    task automatic drain(input bit rnd);
        bit taken = 1'b0;
        int w = 0;
        while (!taken && w < 40) begin
            bus_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            taken = bus_if.out_ready;
            @(posedge clk); #1; w++;
        end
        bus_if.out_ready = 1'b0;
        chk("drain_out_valid_low", 32'(bus_if.out_valid), 0);
        chk("drain_in_ready_high", 32'(bus_if.in_ready), 1);
    endtask

    task automatic one_op(input int a, input int b, input bit rnd, input string tag);
        int lat;
        accept(a, b);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), (b == 0) ? 1 : DW);
        check_result(a, b, tag);
        drain(rnd);
    endtask

    initial begin
        int dir_a[5] = '{200, 255, 6, 5, 100};
        int dir_b[5] = '{7, 15, 3, 9, 0};
        int lat;

        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.dividend  = '0;
        bus_if.divisor   = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus_if.in_ready), 1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 0);
        chk("rst_quot", 32'(bus_if.quotient), 0);
        chk("rst_rem", 32'(bus_if.remainder), 0);
`ifdef DIVIDER_DIV0_FLAG_EN
        chk("rst_div0", 32'(bus_if.div0), 0);
`endif
        rst = 1'b0;

        // Directed cases.
        for (int i = 0; i < 5; i++) one_op(dir_a[i], dir_b[i], 1'b0, "dir");

        // Stall in DONE while the input side wiggles.
        accept(200, 7);
        wait_done(lat);
        chk("stall_latency", 32'(lat), DW);
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = 1'($urandom);
            bus_if.dividend = DW'($urandom);
            bus_if.divisor  = SW'($urandom);
            @(posedge clk); #1;
            chk("stall_quot", 32'(bus_if.quotient), 28);
            chk("stall_rem", 32'(bus_if.remainder), 4);
            chk("stall_in_ready", 32'(bus_if.in_ready), 0);
            chk("stall_out_valid", 32'(bus_if.out_valid), 1);
        end
        bus_if.in_valid = 1'b0;
        drain(1'b0);

        // Reset in the 4th RUN cycle aborts the operation.
        accept(200, 7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(bus_if.in_ready), 1);
        chk("midrst_out_valid", 32'(bus_if.out_valid), 0);
        chk("midrst_quot", 32'(bus_if.quotient), 0);
        chk("midrst_rem", 32'(bus_if.remainder), 0);
`ifdef DIVIDER_DIV0_FLAG_EN
        chk("midrst_div0", 32'(bus_if.div0), 0);
`endif
        one_op(9, 2, 1'b0, "after_rst");

        // Full operand sweep with random consumer back-pressure.
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                one_op(a, b, 1'b1, "sweep");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
